// File: rtl/axi_vfifo_mc_ctrl_pkg.sv
// Shared definitions for the multi-channel AXI virtual FIFO control core:
// channel state encodings and burst size derivation.
package axi_vfifo_mc_ctrl_pkg;

  typedef logic [1:0] ch_state_t;

  localparam ch_state_t ST_RESET  = 2'd0;
  localparam ch_state_t ST_IDLE   = 2'd1;
  localparam ch_state_t ST_ACTIVE = 2'd2;

  // Bytes moved by one fixed-size burst.
  function automatic int unsigned burst_bytes(input int unsigned beats, input int unsigned strb);
    return beats * strb;
  endfunction

endpackage

// File: rtl/axi_vfifo_mc_rr_arb.sv
// Round-robin arbiter: the search starts at the channel after the last
// accepted grant; the pointer only moves when adv is high and a grant exists.
module axi_vfifo_mc_rr_arb #(
  parameter int unsigned CH_CNT = 4,
  parameter int unsigned CL_CH  = $clog2(CH_CNT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CH_CNT-1:0] req,
  input  logic              adv,
  output logic              gnt_vld_c,
  output logic [CH_CNT-1:0] gnt_oh_c,
  output logic [CL_CH-1:0]  gnt_idx_c
);

  logic [CL_CH-1:0] prio_q;
  logic [CL_CH-1:0] idx_c;

  always_comb begin
    gnt_vld_c = 1'b0;
    gnt_oh_c  = '0;
    gnt_idx_c = '0;
    idx_c     = '0;
    for (int unsigned i = 0; i < CH_CNT; i++) begin
      idx_c = CL_CH'((32'(prio_q) + i) % CH_CNT);
      if (!gnt_vld_c && req[idx_c]) begin
        gnt_vld_c = 1'b1;
        gnt_idx_c = idx_c;
      end
    end
    if (gnt_vld_c) gnt_oh_c[gnt_idx_c] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= '0;
    end else if (adv && gnt_vld_c) begin
      prio_q <= (gnt_idx_c == CL_CH'(CH_CNT - 1)) ? '0 : gnt_idx_c + CL_CH'(1);
    end
  end

endmodule

// File: rtl/axi_vfifo_mc_ctrl.sv
// Multi-channel AXI virtual FIFO control core: per-channel ring pointers and
// reset/flush sequencing plus round-robin scheduling of write/read bursts.
module axi_vfifo_mc_ctrl
  import axi_vfifo_mc_ctrl_pkg::*;
#(
  parameter int unsigned CH_CNT         = 4,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_STRB_WIDTH = 8,
  parameter int unsigned BURST_LEN      = 16,
  parameter int unsigned LEN_WIDTH      = AXI_ADDR_WIDTH,
  parameter int unsigned CL_CH          = $clog2(CH_CNT)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [CH_CNT*AXI_ADDR_WIDTH-1:0]  cfg_base_addr,
  input  logic [CH_CNT*LEN_WIDTH-1:0]       cfg_size_mask,
  input  logic [CH_CNT-1:0]                 cfg_enable,
  input  logic [CH_CNT-1:0]                 cfg_reset,
  input  logic [CH_CNT-1:0]                 wr_burst_rdy,
  input  logic [CH_CNT-1:0]                 rd_space_rdy,
  output logic [AXI_ADDR_WIDTH-1:0]         wr_cmd_addr,
  output logic [CL_CH-1:0]                  wr_cmd_ch,
  output logic                              wr_cmd_valid,
  input  logic                              wr_cmd_ready,
  input  logic                              wr_done_valid,
  input  logic [CL_CH-1:0]                  wr_done_ch,
  output logic [AXI_ADDR_WIDTH-1:0]         rd_cmd_addr,
  output logic [CL_CH-1:0]                  rd_cmd_ch,
  output logic                              rd_cmd_valid,
  input  logic                              rd_cmd_ready,
  input  logic                              rd_done_valid,
  input  logic [CL_CH-1:0]                  rd_done_ch,
  output logic [CH_CNT*(LEN_WIDTH+1)-1:0]   sts_occupancy,
  output logic [CH_CNT-1:0]                 sts_empty,
  output logic [CH_CNT-1:0]                 sts_full,
  output logic [CH_CNT-1:0]                 sts_reset,
  output logic [CH_CNT-1:0]                 sts_active
);

  localparam int unsigned PW = LEN_WIDTH + 1;
  localparam int unsigned BB = burst_bytes(BURST_LEN, AXI_STRB_WIDTH);
  localparam logic [PW-1:0]             BB_P    = PW'(BB);
  localparam logic [LEN_WIDTH-1:0]      BB_M1   = LEN_WIDTH'(BB - 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] BB_A_M1 = AXI_ADDR_WIDTH'(BB - 1);

  ch_state_t                 state_q    [CH_CNT];
  ch_state_t                 state_d    [CH_CNT];
  logic [PW-1:0]             wr_start_q [CH_CNT];
  logic [PW-1:0]             wr_start_d [CH_CNT];
  logic [PW-1:0]             wr_finish_q[CH_CNT];
  logic [PW-1:0]             wr_finish_d[CH_CNT];
  logic [PW-1:0]             rd_start_q [CH_CNT];
  logic [PW-1:0]             rd_start_d [CH_CNT];
  logic [PW-1:0]             rd_finish_q[CH_CNT];
  logic [PW-1:0]             rd_finish_d[CH_CNT];
  logic [AXI_ADDR_WIDTH-1:0] base_q     [CH_CNT];
  logic [AXI_ADDR_WIDTH-1:0] base_d     [CH_CNT];
  logic [LEN_WIDTH-1:0]      mask_q     [CH_CNT];
  logic [LEN_WIDTH-1:0]      mask_d     [CH_CNT];
  logic [PW-1:0]             cap_c      [CH_CNT];

  logic [CH_CNT-1:0]         wr_elig_c;
  logic [CH_CNT-1:0]         rd_elig_c;
  logic                      wr_load_c;
  logic                      rd_load_c;
  logic                      wr_gnt_vld_c;
  logic                      rd_gnt_vld_c;
  logic [CH_CNT-1:0]         wr_gnt_oh_c;
  logic [CH_CNT-1:0]         rd_gnt_oh_c;
  logic [CL_CH-1:0]          wr_gnt_idx_c;
  logic [CL_CH-1:0]          rd_gnt_idx_c;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr_c;
  logic [AXI_ADDR_WIDTH-1:0] rd_addr_c;

  // A command slot may be reloaded when it is empty or being accepted.
  assign wr_load_c = !wr_cmd_valid || wr_cmd_ready;
  assign rd_load_c = !rd_cmd_valid || rd_cmd_ready;

  // Burst eligibility from the registered pointers.
  always_comb begin
    for (int ch = 0; ch < CH_CNT; ch++) begin
      cap_c[ch]     = PW'(mask_q[ch]) + PW'(1);
      wr_elig_c[ch] = (state_q[ch] == ST_ACTIVE) && wr_burst_rdy[ch] &&
                      ((wr_start_q[ch] - rd_finish_q[ch] + BB_P) <= cap_c[ch]);
      rd_elig_c[ch] = (state_q[ch] == ST_ACTIVE) && rd_space_rdy[ch] &&
                      ((wr_finish_q[ch] - rd_start_q[ch]) >= BB_P);
    end
  end

  axi_vfifo_mc_rr_arb #(.CH_CNT(CH_CNT), .CL_CH(CL_CH)) u_wr_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (wr_elig_c),
    .adv       (wr_load_c),
    .gnt_vld_c (wr_gnt_vld_c),
    .gnt_oh_c  (wr_gnt_oh_c),
    .gnt_idx_c (wr_gnt_idx_c)
  );

  axi_vfifo_mc_rr_arb #(.CH_CNT(CH_CNT), .CL_CH(CL_CH)) u_rd_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (rd_elig_c),
    .adv       (rd_load_c),
    .gnt_vld_c (rd_gnt_vld_c),
    .gnt_oh_c  (rd_gnt_oh_c),
    .gnt_idx_c (rd_gnt_idx_c)
  );

  always_comb begin
    wr_addr_c = base_q[wr_gnt_idx_c] |
                AXI_ADDR_WIDTH'(wr_start_q[wr_gnt_idx_c][LEN_WIDTH-1:0] & mask_q[wr_gnt_idx_c]);
    rd_addr_c = base_q[rd_gnt_idx_c] |
                AXI_ADDR_WIDTH'(rd_start_q[rd_gnt_idx_c][LEN_WIDTH-1:0] & mask_q[rd_gnt_idx_c]);
  end

  // Per-channel next state: issue, completion and reset/flush sequencing.
  always_comb begin
    for (int ch = 0; ch < CH_CNT; ch++) begin
      state_d[ch]     = state_q[ch];
      wr_start_d[ch]  = wr_start_q[ch];
      wr_finish_d[ch] = wr_finish_q[ch];
      rd_start_d[ch]  = rd_start_q[ch];
      rd_finish_d[ch] = rd_finish_q[ch];
      base_d[ch]      = base_q[ch];
      mask_d[ch]      = mask_q[ch];

      if (wr_load_c && wr_gnt_oh_c[ch]) wr_start_d[ch] = wr_start_q[ch] + BB_P;
      if (rd_load_c && rd_gnt_oh_c[ch]) rd_start_d[ch] = rd_start_q[ch] + BB_P;

      // Stray completions (idle channel or nothing outstanding) are dropped.
      if (wr_done_valid && (wr_done_ch == CL_CH'(ch)) && (state_q[ch] != ST_IDLE) &&
          (wr_finish_q[ch] != wr_start_q[ch]))
        wr_finish_d[ch] = wr_finish_q[ch] + BB_P;
      if (rd_done_valid && (rd_done_ch == CL_CH'(ch)) && (state_q[ch] != ST_IDLE) &&
          (rd_finish_q[ch] != rd_start_q[ch]))
        rd_finish_d[ch] = rd_finish_q[ch] + BB_P;

      case (state_q[ch])
        ST_RESET: begin
          if (!cfg_reset[ch] && (wr_start_q[ch] == wr_finish_q[ch]) &&
              (rd_start_q[ch] == rd_finish_q[ch])) begin
            state_d[ch]     = ST_IDLE;
            wr_start_d[ch]  = '0;
            wr_finish_d[ch] = '0;
            rd_start_d[ch]  = '0;
            rd_finish_d[ch] = '0;
          end
        end
        ST_IDLE: begin
          if (cfg_enable[ch]) begin
            state_d[ch] = ST_ACTIVE;
            base_d[ch]  = cfg_base_addr[ch*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH] & ~BB_A_M1;
            mask_d[ch]  = cfg_size_mask[ch*LEN_WIDTH +: LEN_WIDTH] | BB_M1;
          end
        end
        ST_ACTIVE: ;
        default: state_d[ch] = ST_RESET;
      endcase

      if (cfg_reset[ch]) state_d[ch] = ST_RESET;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int ch = 0; ch < CH_CNT; ch++) begin
        state_q[ch]     <= ST_RESET;
        wr_start_q[ch]  <= '0;
        wr_finish_q[ch] <= '0;
        rd_start_q[ch]  <= '0;
        rd_finish_q[ch] <= '0;
        base_q[ch]      <= '0;
        mask_q[ch]      <= '0;
      end
    end else begin
      for (int ch = 0; ch < CH_CNT; ch++) begin
        state_q[ch]     <= state_d[ch];
        wr_start_q[ch]  <= wr_start_d[ch];
        wr_finish_q[ch] <= wr_finish_d[ch];
        rd_start_q[ch]  <= rd_start_d[ch];
        rd_finish_q[ch] <= rd_finish_d[ch];
        base_q[ch]      <= base_d[ch];
        mask_q[ch]      <= mask_d[ch];
      end
    end
  end

  // Command registers hold their payload until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cmd_valid <= 1'b0;
      wr_cmd_addr  <= '0;
      wr_cmd_ch    <= '0;
      rd_cmd_valid <= 1'b0;
      rd_cmd_addr  <= '0;
      rd_cmd_ch    <= '0;
    end else begin
      if (wr_load_c) begin
        wr_cmd_valid <= wr_gnt_vld_c;
        if (wr_gnt_vld_c) begin
          wr_cmd_addr <= wr_addr_c;
          wr_cmd_ch   <= wr_gnt_idx_c;
        end
      end
      if (rd_load_c) begin
        rd_cmd_valid <= rd_gnt_vld_c;
        if (rd_gnt_vld_c) begin
          rd_cmd_addr <= rd_addr_c;
          rd_cmd_ch   <= rd_gnt_idx_c;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sts_occupancy <= '0;
      sts_empty     <= '1;
      sts_full      <= '0;
      sts_reset     <= '1;
      sts_active    <= '0;
    end else begin
      for (int ch = 0; ch < CH_CNT; ch++) begin
        sts_occupancy[ch*PW +: PW] <= wr_finish_q[ch] - rd_finish_q[ch];
        sts_empty[ch]  <= (wr_finish_q[ch] == rd_finish_q[ch]);
        sts_full[ch]   <= (wr_start_q[ch] - rd_finish_q[ch]) >= (cap_c[ch] - BB_P + PW'(1));
        sts_reset[ch]  <= (state_d[ch] == ST_RESET);
        sts_active[ch] <= (state_d[ch] == ST_ACTIVE);
      end
    end
  end

endmodule

// File: tb/tb_axi_vfifo_mc_ctrl.sv
// Directed bench for axi_vfifo_mc_ctrl: 4 channels, 128-byte bursts, 1 KiB rings.
module tb_axi_vfifo_mc_ctrl;

  localparam int unsigned CH_CNT = 4;
  localparam int unsigned AW     = 32;
  localparam int unsigned LW     = 32;
  localparam int unsigned CL     = 2;
  localparam int unsigned PW     = LW + 1;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [CH_CNT*AW-1:0]   cfg_base_addr;
  logic [CH_CNT*LW-1:0]   cfg_size_mask;
  logic [CH_CNT-1:0]      cfg_enable;
  logic [CH_CNT-1:0]      cfg_reset;
  logic [CH_CNT-1:0]      wr_burst_rdy;
  logic [CH_CNT-1:0]      rd_space_rdy;
  logic [AW-1:0]          wr_cmd_addr;
  logic [CL-1:0]          wr_cmd_ch;
  logic                   wr_cmd_valid;
  logic                   wr_cmd_ready;
  logic                   wr_done_valid;
  logic [CL-1:0]          wr_done_ch;
  logic [AW-1:0]          rd_cmd_addr;
  logic [CL-1:0]          rd_cmd_ch;
  logic                   rd_cmd_valid;
  logic                   rd_cmd_ready;
  logic                   rd_done_valid;
  logic [CL-1:0]          rd_done_ch;
  logic [CH_CNT*PW-1:0]   sts_occupancy;
  logic [CH_CNT-1:0]      sts_empty;
  logic [CH_CNT-1:0]      sts_full;
  logic [CH_CNT-1:0]      sts_reset;
  logic [CH_CNT-1:0]      sts_active;

  int n_run  = 0;
  int n_fail = 0;

  logic [AW-1:0] q[$];
  logic [34:0]   exp_cmd[8];

  always #5 clk = ~clk;

  axi_vfifo_mc_ctrl #(
    .CH_CNT(CH_CNT), .AXI_ADDR_WIDTH(AW), .AXI_STRB_WIDTH(8), .BURST_LEN(16), .LEN_WIDTH(LW), .CL_CH(CL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_base_addr(cfg_base_addr), .cfg_size_mask(cfg_size_mask),
    .cfg_enable(cfg_enable), .cfg_reset(cfg_reset),
    .wr_burst_rdy(wr_burst_rdy), .rd_space_rdy(rd_space_rdy),
    .wr_cmd_addr(wr_cmd_addr), .wr_cmd_ch(wr_cmd_ch), .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
    .wr_done_valid(wr_done_valid), .wr_done_ch(wr_done_ch),
    .rd_cmd_addr(rd_cmd_addr), .rd_cmd_ch(rd_cmd_ch), .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_done_valid(rd_done_valid), .rd_done_ch(rd_done_ch),
    .sts_occupancy(sts_occupancy), .sts_empty(sts_empty), .sts_full(sts_full),
    .sts_reset(sts_reset), .sts_active(sts_active)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] occ(input int ch);
    return sts_occupancy[ch*PW +: PW];
  endfunction

  function automatic logic [34:0] wr_cmd_word();
    return {wr_cmd_valid, wr_cmd_ch, wr_cmd_addr};
  endfunction

  initial begin
    rst_n         = 1'b1;
    cfg_base_addr = {32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000};
    cfg_size_mask = {4{32'h0000_03FF}};
    cfg_enable    = 4'hF;
    cfg_reset     = 4'h0;
    wr_burst_rdy  = 4'h0;
    rd_space_rdy  = 4'h0;
    wr_cmd_ready  = 1'b0;
    rd_cmd_ready  = 1'b0;
    wr_done_valid = 1'b0;
    wr_done_ch    = '0;
    rd_done_valid = 1'b0;
    rd_done_ch    = '0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_sts_reset",  64'(sts_reset), 64'hF);
    check_eq("rst_sts_active", 64'(sts_active), 64'h0);
    check_eq("rst_sts_empty",  64'(sts_empty), 64'hF);
    check_eq("rst_sts_full",   64'(sts_full), 64'h0);
    check_eq("rst_cmd_valid",  64'({wr_cmd_valid, rd_cmd_valid}), 64'h0);
    check_eq("rst_occ0",       64'(occ(0)), 64'h0);
    #10 rst_n = 1'b1;

    // RESET -> IDLE -> ACTIVE
    step();
    check_eq("idle_sts_reset", 64'(sts_reset), 64'h0);
    check_eq("idle_sts_active", 64'(sts_active), 64'h0);
    step();
    check_eq("act_sts_active", 64'(sts_active), 64'hF);

    // Fill ch0: 8 bursts then stall on full
    wr_burst_rdy = 4'h1;
    wr_cmd_ready = 1'b1;
    q.delete();
    for (int i = 0; i < 12; i++) begin
      step();
      if (wr_cmd_valid) q.push_back(wr_cmd_addr);
    end
    wr_burst_rdy = 4'h0;
    check_eq("fill_cnt", 64'(q.size()), 64'd8);
    foreach (q[i]) check_eq($sformatf("fill_addr%0d", i), 64'(q[i]), 64'(i * 128));
    check_eq("fill_full", 64'(sts_full), 64'h1);
    check_eq("fill_empty", 64'(sts_empty), 64'hF);

    // Retire the 8 writes
    wr_done_valid = 1'b1;
    wr_done_ch    = 2'd0;
    repeat (8) step();
    wr_done_valid = 1'b0;
    step();
    check_eq("wdone_occ0", 64'(occ(0)), 64'h400);
    check_eq("wdone_empty", 64'(sts_empty), 64'hE);

    // Drain ch0 with 8 reads
    rd_space_rdy = 4'h1;
    rd_cmd_ready = 1'b1;
    q.delete();
    for (int i = 0; i < 12; i++) begin
      step();
      if (rd_cmd_valid) q.push_back(rd_cmd_addr);
    end
    rd_space_rdy = 4'h0;
    check_eq("drain_cnt", 64'(q.size()), 64'd8);
    foreach (q[i]) check_eq($sformatf("drain_addr%0d", i), 64'(q[i]), 64'(i * 128));
    rd_done_valid = 1'b1;
    rd_done_ch    = 2'd0;
    repeat (8) step();
    rd_done_valid = 1'b0;
    step();
    check_eq("drain_empty", 64'(sts_empty), 64'hF);
    check_eq("drain_occ0", 64'(occ(0)), 64'h0);
    check_eq("drain_full", 64'(sts_full), 64'h0);

    // Next write wraps to ring offset 0
    wr_burst_rdy = 4'h1;
    step();
    wr_burst_rdy = 4'h0;
    check_eq("wrap_cmd", 64'(wr_cmd_word()), 64'({1'b1, 2'd0, 32'h0}));
    step();
    check_eq("wrap_drop", 64'(wr_cmd_valid), 64'h0);
    wr_done_valid = 1'b1;
    wr_done_ch    = 2'd0;
    step();
    wr_done_valid = 1'b0;

    // Round robin across all channels; last write grant was ch0
    exp_cmd[0] = {1'b1, 2'd1, 32'h0001_0000};
    exp_cmd[1] = {1'b1, 2'd2, 32'h0002_0000};
    exp_cmd[2] = {1'b1, 2'd3, 32'h0003_0000};
    exp_cmd[3] = {1'b1, 2'd0, 32'h0000_0080};
    exp_cmd[4] = {1'b1, 2'd1, 32'h0001_0080};
    exp_cmd[5] = {1'b1, 2'd2, 32'h0002_0080};
    exp_cmd[6] = {1'b1, 2'd3, 32'h0003_0080};
    exp_cmd[7] = {1'b1, 2'd0, 32'h0000_0100};
    wr_burst_rdy = 4'hF;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq($sformatf("rr_cmd%0d", k), 64'(wr_cmd_word()), 64'(exp_cmd[k]));
    end
    wr_cmd_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq($sformatf("stall_hold%0d", k), 64'(wr_cmd_word()), 64'(exp_cmd[4]));
    end
    wr_cmd_ready = 1'b1;
    for (int k = 5; k < 8; k++) begin
      step();
      check_eq($sformatf("rr_cmd%0d", k), 64'(wr_cmd_word()), 64'(exp_cmd[k]));
    end
    wr_burst_rdy = 4'h0;
    step();
    check_eq("rr_idle", 64'(wr_cmd_valid), 64'h0);

    // Channel reset with two ch1 writes outstanding
    cfg_reset  = 4'h2;
    cfg_enable = 4'hD;
    step();
    cfg_reset    = 4'h0;
    wr_burst_rdy = 4'h2;
    check_eq("chrst_sts_reset", 64'(sts_reset), 64'h2);
    check_eq("chrst_sts_active", 64'(sts_active), 64'hD);
    begin
      logic seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
        step();
        seen = seen | wr_cmd_valid;
      end
      check_eq("chrst_no_issue", 64'(seen), 64'h0);
    end
    wr_done_valid = 1'b1;
    wr_done_ch    = 2'd1;
    step();
    wr_done_valid = 1'b0;
    step();
    check_eq("chrst_hold1", 64'(sts_reset), 64'h2);
    wr_done_valid = 1'b1;
    step();
    wr_done_valid = 1'b0;
    check_eq("chrst_hold2", 64'(sts_reset), 64'h2);
    step();
    check_eq("chrst_idle_reset", 64'(sts_reset), 64'h0);
    check_eq("chrst_idle_active", 64'(sts_active), 64'hD);
    step();
    check_eq("chrst_occ1", 64'(occ(1)), 64'h0);
    check_eq("chrst_empty", 64'(sts_empty), 64'hE);
    wr_burst_rdy = 4'h0;

    // Stray completions: ch1 idle, ch0 has no read outstanding
    wr_done_valid = 1'b1;
    wr_done_ch    = 2'd1;
    rd_done_valid = 1'b1;
    rd_done_ch    = 2'd0;
    step();
    wr_done_valid = 1'b0;
    rd_done_valid = 1'b0;
    step();
    step();
    check_eq("stray_occ1", 64'(occ(1)), 64'h0);
    check_eq("stray_occ0", 64'(occ(0)), 64'h80);
    check_eq("stray_empty", 64'(sts_empty), 64'hE);
    wr_done_valid = 1'b1;
    wr_done_ch    = 2'd2;
    step();
    wr_done_valid = 1'b0;
    step();
    check_eq("legal_occ2", 64'(occ(2)), 64'h80);

    // Asynchronous reset in the middle of traffic
    wr_burst_rdy = 4'hD;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_cmd_valid", 64'({wr_cmd_valid, rd_cmd_valid}), 64'h0);
    check_eq("arst_sts_reset", 64'(sts_reset), 64'hF);
    check_eq("arst_sts_active", 64'(sts_active), 64'h0);
    check_eq("arst_sts_empty", 64'(sts_empty), 64'hF);
    check_eq("arst_sts_full", 64'(sts_full), 64'h0);
    check_eq("arst_occ", 64'(sts_occupancy[63:0]), 64'h0);
    #2 rst_n = 1'b1;
    step();
    step();
    check_eq("rerun_active", 64'(sts_active), 64'hD);
    check_eq("rerun_reset", 64'(sts_reset), 64'h0);
    step();
    check_eq("rerun_cmd", 64'(wr_cmd_word()), 64'({1'b1, 2'd0, 32'h0}));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
